// File: rtl/sticky_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sticky_pkg
// Description : Shared constants and FSM state encoding for the sticky event
//               reader: default channel count and the IDLE/VALID read states.
// Revision    : 1.0 - initial release
// ============================================================================
package sticky_pkg;

    localparam int c_N_EV_DEFAULT = 8;

    // Read-handshake states. IDLE: no snapshot held. VALID: snapshot presented.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sticky_event_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : sticky_event_reader_if
// Description : Event/reader bus of the sticky event reader. Signal names are
//               given from the reader block's point of view.
//   i_ev       : event levels (rising edge = one event)
//   i_rd_req   : reader requests a snapshot
//   i_rd_ack   : reader consumed the snapshot, clear-on-read
//   o_rd_valid : snapshot on o_rd_data/o_rd_ovr is stable
//   o_rd_data  : snapshot of sticky flags
//   o_rd_ovr   : snapshot of overrun flags
//   o_irq      : any sticky flag set
// Revision    : 1.0 - initial release
// ============================================================================
interface sticky_event_reader_if
    import sticky_pkg::*;
#(
    parameter int N_EV = c_N_EV_DEFAULT
);
    logic [N_EV-1:0] i_ev;
    logic            i_rd_req;
    logic            i_rd_ack;
    logic            o_rd_valid;
    logic [N_EV-1:0] o_rd_data;
    logic [N_EV-1:0] o_rd_ovr;
    logic            o_irq;

    // Event source / reader side.
    modport master (
        output i_ev, i_rd_req, i_rd_ack,
        input  o_rd_valid, o_rd_data, o_rd_ovr, o_irq
    );

    // Sticky event reader side.
    modport slave (
        input  i_ev, i_rd_req, i_rd_ack,
        output o_rd_valid, o_rd_data, o_rd_ovr, o_irq
    );
endinterface
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect
// Description : Per-bit rising-edge detector. o_rise[i] is high in the cycle
//               where i_d[i] is 1 and was 0 on the previous clock.
//   clk, rst : clock and synchronous active-high reset
//   i_d      : input levels
//   o_rise   : combinational rising-edge strobe
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_rise
);
    logic [WIDTH-1:0] r_prev;

    // History tracks the input during reset too, so a level already high
    // when reset is released does not look like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= i_d;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/sticky_event_reader.sv
`default_nettype none
// ============================================================================
// Module      : sticky_event_reader
// Description : Sticky event flags with overrun tracking and a two-state
//               snapshot/clear-on-read handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : sticky_event_reader_if.slave (events, read handshake, irq)
// Revision    : 1.0 - initial release
// ============================================================================
module sticky_event_reader
    import sticky_pkg::*;
#(
    parameter int N_EV = c_N_EV_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    sticky_event_reader_if.slave   bus
);
    localparam logic [0:0] c_ST_IDLE  = IDLE;
    localparam logic [0:0] c_ST_VALID = VALID;

    logic [0:0]      r_state;
    logic [N_EV-1:0] r_flag;
    logic [N_EV-1:0] r_ovr;
    logic [N_EV-1:0] r_snap;
    logic [N_EV-1:0] r_snap_ovr;
    logic            r_rd_valid;
    logic            r_irq;

    logic [N_EV-1:0] w_rise;
    logic            w_ack_take;
    logic [N_EV-1:0] w_clr_flag;
    logic [N_EV-1:0] w_clr_ovr;
    logic [N_EV-1:0] w_flag_next;
    logic [N_EV-1:0] w_ovr_next;

    edge_detect #(
        .WIDTH (N_EV)
    ) u_edge_detect (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.i_ev),
        .o_rise (w_rise)
    );

    // Only the bits captured in the snapshot are cleared, so events that
    // arrived after the snapshot survive the read.
    assign w_ack_take = (r_state == c_ST_VALID) && bus.i_rd_ack;
    assign w_clr_flag = w_ack_take ? r_snap     : '0;
    assign w_clr_ovr  = w_ack_take ? r_snap_ovr : '0;

    // Set wins over clear. An event on a bit being cleared this cycle is the
    // first event after the read, not an overrun.
    assign w_flag_next = (r_flag & ~w_clr_flag) | w_rise;
    assign w_ovr_next  = (r_ovr & ~w_clr_ovr) | (w_rise & r_flag & ~w_clr_flag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_flag     <= '0;
            r_ovr      <= '0;
            r_snap     <= '0;
            r_snap_ovr <= '0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_flag <= w_flag_next;
            r_ovr  <= w_ovr_next;
            // Computed from the next flag value so irq tracks FLAG exactly.
            r_irq  <= |w_flag_next;
            case (r_state)
                c_ST_IDLE: begin
                    // An ack arriving together with the request is ignored here.
                    if (bus.i_rd_req) begin
                        r_snap     <= r_flag;
                        r_snap_ovr <= r_ovr;
                        r_rd_valid <= 1'b1;
                        r_state    <= c_ST_VALID;
                    end
                end
                c_ST_VALID: begin
                    if (bus.i_rd_ack) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_rd_valid <= 1'b0;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_rd_data  = r_snap;
    assign bus.o_rd_ovr   = r_snap_ovr;
    assign bus.o_irq      = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_sticky_event_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sticky_event_reader
// Description : Directed bench for sticky_event_reader with a per-channel
//               behavioural model checked every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sticky_event_reader;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sticky_event_reader_if #(.N_EV(N)) sif ();

    sticky_event_reader #(.N_EV(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, one entry per channel.
    bit       m_flag  [N];
    bit       m_ovr   [N];
    bit       m_prev  [N];
    bit [N-1:0] m_snap;
    bit [N-1:0] m_snap_ovr;
    bit       m_valid;
    bit       m_ready = 1'b0;

    function automatic bit [N-1:0] pack(input bit a [N]);
        bit [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel event is a 0->1 transition of its input; a flagged
    // channel that sees another event overruns; an acknowledged read forgets
    // exactly what it reported; a new event beats the forgetting.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_flag[i] = 0; m_ovr[i] = 0; m_prev[i] = sif.i_ev[i];
            end
            m_snap = '0; m_snap_ovr = '0; m_valid = 0; m_ready = 1;
        end else begin
            bit         taking;
            bit [N-1:0] old_flags, old_ovr;
            taking    = m_valid && (sif.i_rd_ack === 1'b1);
            old_flags = pack(m_flag);
            old_ovr   = pack(m_ovr);
            for (int i = 0; i < N; i++) begin
                bit happened, reported, reported_ovr;
                happened     = sif.i_ev[i] && !m_prev[i];
                reported     = taking && m_snap[i];
                reported_ovr = taking && m_snap_ovr[i];
                if (reported)     m_flag[i] = 0;
                if (reported_ovr) m_ovr[i]  = 0;
                if (happened) begin
                    if (m_flag[i]) m_ovr[i] = 1;
                    m_flag[i] = 1;
                end
                m_prev[i] = sif.i_ev[i];
            end
            if (!m_valid && sif.i_rd_req) begin
                m_snap = old_flags; m_snap_ovr = old_ovr; m_valid = 1;
            end else if (taking) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("rd_valid", {7'b0, sif.o_rd_valid}, {7'b0, m_valid});
            chk("irq",      {7'b0, sif.o_irq},      {7'b0, |pack(m_flag)});
            if (m_valid) begin
                chk("rd_data", sif.o_rd_data, m_snap);
                chk("rd_ovr",  sif.o_rd_ovr,  m_snap_ovr);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [N-1:0] v);
        sif.i_ev = v; step(); sif.i_ev = '0; step();
    endtask

    task automatic read_lit(input string name, input logic [N-1:0] d, input logic [N-1:0] o);
        sif.i_rd_req = 1; step(); sif.i_rd_req = 0;
        chk({name, "_valid"}, {7'b0, sif.o_rd_valid}, 8'h01);
        chk({name, "_data"},  sif.o_rd_data, d);
        chk({name, "_ovr"},   sif.o_rd_ovr,  o);
        sif.i_rd_ack = 1; step(); sif.i_rd_ack = 0;
        chk({name, "_done"}, {7'b0, sif.o_rd_valid}, 8'h00);
    endtask

    initial begin
        sif.i_ev = 8'hFF; sif.i_rd_req = 0; sif.i_rd_ack = 0;
        rst = 1; step(3);
        rst = 0; step(2);
        chk("rst_hi_irq", {7'b0, sif.o_irq}, 8'h00);
        sif.i_ev = 8'h00; step();
        sif.i_ev = 8'h01; step();
        chk("ev0_irq", {7'b0, sif.o_irq}, 8'h01);
        sif.i_ev = 8'h00; step();
        read_lit("ev0", 8'h01, 8'h00);
        chk("ev0_irq_clr", {7'b0, sif.o_irq}, 8'h00);

        // Double event on bit 3 -> overrun.
        pulse(8'h08); pulse(8'h08);
        read_lit("ovr3", 8'h08, 8'h08);
        read_lit("ovr3_again", 8'h00, 8'h00);
        chk("ovr3_irq", {7'b0, sif.o_irq}, 8'h00);

        // Event during VALID survives the clear; rd_req held is ignored.
        pulse(8'h01);
        sif.i_rd_req = 1; step();
        sif.i_ev = 8'h20; step(); sif.i_ev = 8'h00; sif.i_rd_req = 0; step();
        chk("mid_data", sif.o_rd_data, 8'h01);
        chk("mid_valid", {7'b0, sif.o_rd_valid}, 8'h01);
        sif.i_rd_ack = 1; step(); sif.i_rd_ack = 0;
        chk("mid_irq", {7'b0, sif.o_irq}, 8'h01);
        read_lit("mid_after", 8'h20, 8'h00);

        // Event in the ack cycle on a bit being cleared: set wins, no overrun.
        pulse(8'h02);
        sif.i_rd_req = 1; step(); sif.i_rd_req = 0;
        sif.i_ev = 8'h02; sif.i_rd_ack = 1; step();
        sif.i_ev = 8'h00; sif.i_rd_ack = 0; step();
        chk("race_irq", {7'b0, sif.o_irq}, 8'h01);
        read_lit("race", 8'h02, 8'h00);

        // Reset mid-read.
        pulse(8'h81);
        sif.i_rd_req = 1; step(); sif.i_rd_req = 0;
        chk("pre_rst_data", sif.o_rd_data, 8'h81);
        rst = 1; step(); rst = 0;
        chk("rst_valid", {7'b0, sif.o_rd_valid}, 8'h00);
        chk("rst_irq",   {7'b0, sif.o_irq},      8'h00);
        step();
        read_lit("post_rst", 8'h00, 8'h00);

        // Ack in IDLE does nothing; req+ack together acts as req only.
        sif.i_rd_ack = 1; step(2); sif.i_rd_ack = 0;
        chk("idle_ack", {7'b0, sif.o_rd_valid}, 8'h00);
        pulse(8'h04);
        sif.i_rd_req = 1; sif.i_rd_ack = 1; step(); sif.i_rd_req = 0;
        chk("reqack_valid", {7'b0, sif.o_rd_valid}, 8'h01);
        chk("reqack_data", sif.o_rd_data, 8'h04);
        step(); sif.i_rd_ack = 0;
        chk("reqack_done", {7'b0, sif.o_rd_valid}, 8'h00);
        chk("reqack_irq",  {7'b0, sif.o_irq},      8'h00);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sticky_event_reader.md
STICKY_EVENT_READER -- requirements
Module: sticky_event_reader

Interface
REQ-001 Parameter N_EV, default 8, number of event channels.
REQ-002 CLK  input  1  rising-edge clock; sole clock of the block.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-004 EV  input  N_EV  event levels, synchronous to CLK; a rising edge on a bit is one event.
REQ-005 RD_REQ  input  1  reader requests a snapshot of the sticky flags.
REQ-006 RD_ACK  input  1  reader has consumed RD_DATA; commands clear-on-read.
REQ-007 RD_VALID  output  1  RD_DATA and RD_OVR hold a stable snapshot.
REQ-008 RD_DATA  output  N_EV  snapshot of the sticky flags.
REQ-009 RD_OVR  output  N_EV  snapshot of the per-bit overrun flags.
REQ-010 IRQ  output  1  high whenever any sticky flag is set.

Function
REQ-011 Edge detect: a bit SHALL register an event when EV[i]=1 and EV_prev[i]=0, where EV_prev is EV delayed one CLK.
REQ-012 On an event, FLAG[i] SHALL be 1 from the next edge onward, and SHALL hold until cleared by a completed read (SR-latch semantics).
REQ-013 An event on a bit whose FLAG[i] is already 1 SHALL set OVR[i]; OVR[i] holds until cleared by a completed read.
REQ-014 IRQ SHALL equal the OR of all FLAG bits, registered, with no extra latency beyond FLAG.
REQ-015 FSM states SHALL be IDLE and VALID only.
REQ-016 IDLE with RD_REQ=1 at edge n: SNAP<=FLAG, SNAP_OVR<=OVR; state VALID; RD_VALID=1 from edge n (one-cycle latency).
REQ-017 In VALID, RD_DATA/RD_OVR SHALL remain constant; new events update FLAG/OVR but not the snapshot.
REQ-018 In VALID, RD_REQ SHALL be ignored.
REQ-019 In VALID with RD_ACK=1: clear only the bits set in SNAP (FLAG &= ~SNAP, OVR &= ~SNAP_OVR); return to IDLE; RD_VALID=0 next cycle.
REQ-020 RD_ACK in IDLE SHALL have no effect.
REQ-021 An event on bit i in the same cycle as its clear SHALL leave FLAG[i]=1 (set wins) and SHALL NOT set OVR[i].
REQ-022 RD_REQ with all flags zero SHALL still complete a read returning RD_DATA=0.
REQ-023 RD_REQ and RD_ACK high together in IDLE SHALL act as RD_REQ only; the ACK is taken in the following VALID cycle if still high.

Reset
REQ-024 RESET=1 at an edge SHALL force FLAG=0, OVR=0, SNAP=0, SNAP_OVR=0, state IDLE, RD_VALID=0, IRQ=0.
REQ-025 During reset, EV_prev SHALL load EV, so inputs already high at reset release produce no event.
REQ-026 Reset mid-read (state VALID) SHALL abandon the read with no clear of pending events; all flags read 0 afterward.

Structure
REQ-027 Package sticky_pkg SHALL hold the N_EV default and the FSM state enum (IDLE, VALID).
REQ-028 Rising-edge detection SHALL live in sub-module edge_detect (parameterised width, same CLK/RESET), instantiated once.
REQ-029 Every register SHALL be updated in a single clocked process; outputs SHALL be driven only from registers.

Verification
REQ-030 Reset with EV=8'hFF held -> after release, no flag set, IRQ=0; drop EV to 0 and raise EV[0] -> FLAG=8'h01, IRQ=1 next cycle.
REQ-031 Pulse EV[3] twice, then RD_REQ -> RD_VALID next cycle, RD_DATA=8'h08, RD_OVR=8'h08; RD_ACK -> RD_DATA of next read =0, IRQ=0.
REQ-032 Snapshot of 8'h01, event EV[5] during VALID, then RD_ACK -> FLAG=8'h20 remains, IRQ=1, RD_DATA unchanged during VALID.
REQ-033 Snapshot 8'h02, EV[1] edge in the RD_ACK cycle -> FLAG[1]=1 after clear, OVR[1]=0.
REQ-034 RESET asserted while RD_VALID=1 with FLAG=8'h81 -> next cycle RD_VALID=0, FLAG=0, IRQ=0.
REQ-035 RD_REQ with no events -> RD_VALID=1, RD_DATA=0, RD_OVR=0; RD_ACK in IDLE -> no state change.
